// File: rtl/alu_seq_if.sv
// Request and result handshake channels of alu_seq.
// The sequencer side uses the master modport, the ALU uses the slave modport.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             zero;
    logic             div_zero;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, zero, div_zero
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, zero, div_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Registered eight-operation ALU with valid/ready handshakes.
// Single-cycle ops and divide-by-zero complete on the accept edge; DIV/MOD
// with a non-zero divisor run a WIDTH-step restoring divider.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic             mod_q;
    logic [WIDTH:0]   result_q;
    logic             zero_q, dz_q;

    logic             accept, is_div_op, b_zero, start_div, load_single, last_step;
    logic [WIDTH:0]   shifted, trial, single_res, div_res;
    logic [WIDTH-1:0] quo_nx, rem_nx;

    // Result of every op that completes on the accept edge; the DIV/MOD
    // entries are only reached when the divisor is zero.
    function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       sel);
        logic [WIDTH:0] r;
        r = '0;
        case (sel)
            OP_PASS: r = {1'b0, a};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_DIV:  r = {1'b0, {WIDTH{1'b1}}};
            OP_MOD:  r = {1'b0, a};
            OP_SHL:  r = {a, 1'b0};
            OP_SHR:  r = {2'b00, a[WIDTH-1:1]};
            OP_GT:   r = {{WIDTH{1'b0}}, (a > b)};
        endcase
        return r;
    endfunction

    assign is_div_op   = (bus.sel == OP_DIV) || (bus.sel == OP_MOD);
    assign b_zero      = (bus.b == '0);
    assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign start_div   = accept && is_div_op && !b_zero;
    assign load_single = accept && !start_div;
    assign last_step   = (state_q == DIV) && (cnt_q == LAST);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only when it does not borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    assign single_res = alu_op(bus.a, bus.b, bus.sel);
    assign div_res    = mod_q ? {1'b0, rem_nx} : {1'b0, quo_nx};

    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.div_zero  = dz_q;

    // Next-state logic; an accept from DONE restarts exactly as from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = start_div ? DIV : DONE;
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset also abandons any division in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divider step counter, restarted on every divide accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_div) begin
            cnt_q <= '0;
        end else if (state_q == DIV) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Output registers: loaded on single-cycle accept or on the last divide step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else if (load_single) begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
            dz_q     <= is_div_op && b_zero;
        end else if (last_step) begin
            result_q <= div_res;
            zero_q   <= (div_res == '0);
            dz_q     <= 1'b0;
        end
    end

    // Divider working registers; contents are irrelevant outside DIV.
    always_ff @(posedge clk) begin
        if (start_div) begin
            quo_q <= bus.a;
            rem_q <= '0;
            dvs_q <= bus.b;
            mod_q <= (bus.sel == OP_MOD);
        end else if (state_q == DIV) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end
endmodule
